// File: rtl/pe_array_tile_ctrl_pkg.sv
// Shared definitions for the PE array tile sequencer: FSM state encoding and
// register-file bank select values.
package pe_array_tile_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StPreload = 3'd1,
        StRun     = 3'd2,
        StDrain   = 3'd3,
        StDone    = 3'd4
    } ctrl_state_e;

    // Bank under compute; the load side always writes the opposite bank.
    localparam logic BankA = 1'b0;  // read through r_addr1
    localparam logic BankB = 1'b1;  // read through r_addr2

endpackage

// File: rtl/pe_array_tile_ctrl_rf_wrap_counter.sv
// Free-running address counter for a register-file bank: counts 0..2**WIDTH-1
// on enable, then wraps to 0. The wrap pulse flags the step from the last
// address back to 0 (i.e. a full bank has been walked).
module pe_array_tile_ctrl_rf_wrap_counter #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] value,
    output logic             wrap
);

    logic [WIDTH-1:0] value_q;

    // Address register; clear takes priority over counting.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            value_q <= '0;
        end else if (en) begin
            value_q <= value_q + 1'b1;
        end
    end

    assign value = value_q;
    assign wrap  = en & (value_q == {WIDTH{1'b1}});

endmodule

// File: rtl/pe_array_tile_ctrl.sv
// Ping-pong tile sequencer for the PE array: loads one tile of activation and
// weight words from the GBF bus into the idle RF bank while the array computes
// on the other bank, then swaps banks at the tile boundary.
module pe_array_tile_ctrl
    import pe_array_tile_ctrl_pkg::*;
#(
    parameter int unsigned ROW                = 16,
    parameter int unsigned COL                = 16,
    parameter int unsigned RF_ADDR_BITWIDTH   = 2,
    parameter int unsigned PSUM_ADDR_BITWIDTH = 2,
    parameter int unsigned TILE_BITWIDTH      = 8,
    parameter int unsigned MAC_LATENCY        = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [TILE_BITWIDTH-1:0]      cfg_num_tiles,
    input  logic [ROW*COL-1:0]            cfg_pe_mask,
    input  logic                          gbf_valid,
    output logic                          gbf_ready,
    output logic                          actv_sel,
    output logic                          wgt_sel,
    output logic [ROW*COL-1:0]            actv_en,
    output logic [ROW*COL-1:0]            wgt_en,
    output logic [RF_ADDR_BITWIDTH-1:0]   actv_w_addr,
    output logic [RF_ADDR_BITWIDTH-1:0]   wgt_w_addr,
    output logic [RF_ADDR_BITWIDTH-1:0]   actv_r_addr1,
    output logic [RF_ADDR_BITWIDTH-1:0]   actv_r_addr2,
    output logic [RF_ADDR_BITWIDTH-1:0]   wgt_r_addr1,
    output logic [RF_ADDR_BITWIDTH-1:0]   wgt_r_addr2,
    output logic [ROW*COL-1:0]            MAC_en,
    output logic                          psum_en,
    output logic [PSUM_ADDR_BITWIDTH-1:0] psum_addr1,
    output logic [PSUM_ADDR_BITWIDTH-1:0] psum_addr2,
    output logic [PSUM_ADDR_BITWIDTH-1:0] psum_write_addr,
    output logic                          busy,
    output logic                          done
);

    localparam int unsigned NumPe  = ROW * COL;
    localparam int unsigned DrainW = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;

    ctrl_state_e               state_q;
    logic [TILE_BITWIDTH-1:0]  num_tiles_q;
    logic [NumPe-1:0]          mask_q;
    logic [TILE_BITWIDTH-1:0]  tile_q;
    logic [DrainW-1:0]         drain_q;
    logic                      sel_q;
    logic                      gbf_ready_q;
    logic [NumPe-1:0]          mac_q;
    logic                      computing_q;  // read counter walking the compute bank
    logic                      load_done_q;  // next tile fully written into idle bank
    logic                      psum_en_q;
    logic                      busy_q;
    logic                      done_q;

    logic                        beat;
    logic                        cnt_clr;
    logic                        r_en;
    logic [RF_ADDR_BITWIDTH-1:0] w_addr;
    logic [RF_ADDR_BITWIDTH-1:0] r_addr;
    logic                        w_wrap;
    logic                        r_wrap;
    logic [TILE_BITWIDTH-1:0]    tile_last;
    logic [TILE_BITWIDTH-1:0]    tile_next;
    logic                        last_tile;
    logic                        load_now;
    logic                        rd_done;
    logic                        tile_end;
    logic                        psum_wrap;

    assign beat      = gbf_valid & gbf_ready_q;
    assign cnt_clr   = (state_q == StIdle) & start;
    assign r_en      = (state_q == StRun) & computing_q;
    assign tile_last = num_tiles_q - TILE_BITWIDTH'(1);
    assign tile_next = tile_q + TILE_BITWIDTH'(1);
    assign last_tile = (tile_q == tile_last);
    // The beat that completes the next tile counts in the same cycle, so a
    // load finishing together with the read swaps banks without a bubble.
    assign load_now  = load_done_q | w_wrap;
    assign rd_done   = computing_q ? r_wrap : 1'b1;
    assign tile_end  = rd_done & (load_now | last_tile);
    assign psum_wrap = (tile_q[PSUM_ADDR_BITWIDTH-1:0] == {PSUM_ADDR_BITWIDTH{1'b1}});

    pe_array_tile_ctrl_rf_wrap_counter #(
        .WIDTH(RF_ADDR_BITWIDTH)
    ) u_w_cnt (
        .clk  (clk),
        .reset(reset),
        .en   (beat),
        .clr  (cnt_clr),
        .value(w_addr),
        .wrap (w_wrap)
    );

    pe_array_tile_ctrl_rf_wrap_counter #(
        .WIDTH(RF_ADDR_BITWIDTH)
    ) u_r_cnt (
        .clk  (clk),
        .reset(reset),
        .en   (r_en),
        .clr  (cnt_clr),
        .value(r_addr),
        .wrap (r_wrap)
    );

    // Sequencer FSM with registered control outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            num_tiles_q <= '0;
            mask_q      <= '0;
            tile_q      <= '0;
            drain_q     <= '0;
            sel_q       <= BankA;
            gbf_ready_q <= 1'b0;
            mac_q       <= '0;
            computing_q <= 1'b0;
            load_done_q <= 1'b0;
            psum_en_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        num_tiles_q <= cfg_num_tiles;
                        mask_q      <= cfg_pe_mask;
                        tile_q      <= '0;
                        sel_q       <= BankA;
                        psum_en_q   <= 1'b0;
                        load_done_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (cfg_num_tiles == '0) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q     <= StPreload;
                            gbf_ready_q <= 1'b1;
                        end
                    end
                end
                StPreload: begin
                    if (w_wrap) begin
                        state_q     <= StRun;
                        sel_q       <= ~sel_q;
                        tile_q      <= '0;
                        computing_q <= 1'b1;
                        mac_q       <= mask_q;
                        load_done_q <= 1'b0;
                        gbf_ready_q <= (tile_last != '0);
                    end
                end
                StRun: begin
                    if (w_wrap) begin
                        load_done_q <= 1'b1;
                        gbf_ready_q <= 1'b0;
                    end
                    if (tile_end) begin
                        if (last_tile) begin
                            state_q     <= StDrain;
                            computing_q <= 1'b0;
                            mac_q       <= '0;
                            gbf_ready_q <= 1'b0;
                            drain_q     <= '0;
                        end else begin
                            sel_q       <= ~sel_q;
                            tile_q      <= tile_next;
                            computing_q <= 1'b1;
                            mac_q       <= mask_q;
                            load_done_q <= 1'b0;
                            gbf_ready_q <= (tile_next < tile_last);
                            if (psum_wrap) begin
                                psum_en_q <= ~psum_en_q;
                            end
                        end
                    end else if (rd_done) begin
                        // Compute finished before the next tile arrived: stall.
                        computing_q <= 1'b0;
                        mac_q       <= '0;
                    end
                end
                StDrain: begin
                    if (drain_q == DrainW'(MAC_LATENCY - 1)) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= drain_q + DrainW'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign gbf_ready       = gbf_ready_q;
    assign actv_sel        = sel_q;
    assign wgt_sel         = sel_q;
    assign actv_en         = mask_q & {NumPe{beat}};
    assign wgt_en          = mask_q & {NumPe{beat}};
    assign actv_w_addr     = w_addr;
    assign wgt_w_addr      = w_addr;
    // Only the compute bank sees the read counter; the idle bank reads 0.
    assign actv_r_addr1    = (sel_q == BankA) ? r_addr : '0;
    assign actv_r_addr2    = (sel_q == BankB) ? r_addr : '0;
    assign wgt_r_addr1     = (sel_q == BankA) ? r_addr : '0;
    assign wgt_r_addr2     = (sel_q == BankB) ? r_addr : '0;
    assign MAC_en          = mac_q;
    assign psum_en         = psum_en_q;
    assign psum_addr1      = tile_q[PSUM_ADDR_BITWIDTH-1:0];
    assign psum_addr2      = tile_q[PSUM_ADDR_BITWIDTH-1:0];
    assign psum_write_addr = tile_q[PSUM_ADDR_BITWIDTH-1:0];
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_pe_array_tile_ctrl.sv
// Self-checking bench for pe_array_tile_ctrl. A job-level reference model
// (words accepted, tile under compute, read position) predicts every output
// each cycle; directed jobs add end-to-end latency and MAC-count checks.
module tb_pe_array_tile_ctrl;

    localparam int ROW = 16;
    localparam int COL = 16;
    localparam int RFW = 2;
    localparam int PSW = 2;
    localparam int TW  = 8;
    localparam int ML  = 1;
    localparam int NPE = ROW * COL;
    localparam int D   = 1 << RFW;
    localparam int PD  = 1 << PSW;

    localparam int PhIdle  = 0;
    localparam int PhPre   = 1;
    localparam int PhRun   = 2;
    localparam int PhDrain = 3;
    localparam int PhDone  = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [TW-1:0]  cfg_num_tiles;
    logic [NPE-1:0] cfg_pe_mask;
    logic           gbf_valid;
    logic           gbf_ready;
    logic           actv_sel, wgt_sel;
    logic [NPE-1:0] actv_en, wgt_en, MAC_en;
    logic [RFW-1:0] actv_w_addr, wgt_w_addr;
    logic [RFW-1:0] actv_r_addr1, actv_r_addr2, wgt_r_addr1, wgt_r_addr2;
    logic           psum_en;
    logic [PSW-1:0] psum_addr1, psum_addr2, psum_write_addr;
    logic           busy, done;

    pe_array_tile_ctrl #(
        .ROW               (ROW),
        .COL               (COL),
        .RF_ADDR_BITWIDTH  (RFW),
        .PSUM_ADDR_BITWIDTH(PSW),
        .TILE_BITWIDTH     (TW),
        .MAC_LATENCY       (ML)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .cfg_num_tiles  (cfg_num_tiles),
        .cfg_pe_mask    (cfg_pe_mask),
        .gbf_valid      (gbf_valid),
        .gbf_ready      (gbf_ready),
        .actv_sel       (actv_sel),
        .wgt_sel        (wgt_sel),
        .actv_en        (actv_en),
        .wgt_en         (wgt_en),
        .actv_w_addr    (actv_w_addr),
        .wgt_w_addr     (wgt_w_addr),
        .actv_r_addr1   (actv_r_addr1),
        .actv_r_addr2   (actv_r_addr2),
        .wgt_r_addr1    (wgt_r_addr1),
        .wgt_r_addr2    (wgt_r_addr2),
        .MAC_en         (MAC_en),
        .psum_en        (psum_en),
        .psum_addr1     (psum_addr1),
        .psum_addr2     (psum_addr2),
        .psum_write_addr(psum_write_addr),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    int             phase;
    int             acc;     // words accepted this job
    int             cur;     // tile under compute, -1 before the first
    int             rd;      // read position in current tile, D = read finished
    int             dl;      // drain cycles left
    int             n_m;
    logic [NPE-1:0] mask_m;

    // Per-job observations of the DUT.
    int tk, first_mac, done_at, mac_seen, ready_seen;

    task automatic chk(input string tag, input logic [NPE-1:0] obs, input logic [NPE-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        phase  = PhIdle;
        acc    = 0;
        cur    = -1;
        rd     = 0;
        dl     = 0;
        n_m    = 0;
        mask_m = '0;
    endtask

    // Bus is open during preload, and during compute while a further tile
    // still has to be brought in and has not been fully accepted yet.
    function automatic logic ready_exp();
        return (phase == PhPre) ||
               (phase == PhRun && cur + 1 < n_m && acc < (cur + 2) * D);
    endfunction

    task automatic check_outputs();
        logic           sel_e;
        logic           mac_on;
        logic [NPE-1:0] en_e;
        int             ra, tile_e;
        mac_on = (phase == PhRun) && (rd < D);
        sel_e  = ((cur + 1) % 2) != 0;
        ra     = mac_on ? rd : 0;
        tile_e = (cur < 0) ? 0 : cur;
        en_e   = (gbf_valid && ready_exp()) ? mask_m : '0;
        chk("gbf_ready", NPE'(gbf_ready), NPE'(ready_exp()));
        chk("MAC_en", MAC_en, mac_on ? mask_m : '0);
        chk("actv_en", actv_en, en_e);
        chk("wgt_en", wgt_en, en_e);
        chk("actv_sel", NPE'(actv_sel), NPE'(sel_e));
        chk("wgt_sel", NPE'(wgt_sel), NPE'(sel_e));
        chk("actv_w_addr", NPE'(actv_w_addr), NPE'(acc % D));
        chk("wgt_w_addr", NPE'(wgt_w_addr), NPE'(acc % D));
        chk("actv_r_addr1", NPE'(actv_r_addr1), NPE'(sel_e ? 0 : ra));
        chk("actv_r_addr2", NPE'(actv_r_addr2), NPE'(sel_e ? ra : 0));
        chk("wgt_r_addr1", NPE'(wgt_r_addr1), NPE'(sel_e ? 0 : ra));
        chk("wgt_r_addr2", NPE'(wgt_r_addr2), NPE'(sel_e ? ra : 0));
        chk("psum_en", NPE'(psum_en), NPE'((tile_e / PD) % 2));
        chk("psum_addr1", NPE'(psum_addr1), NPE'(tile_e % PD));
        chk("psum_addr2", NPE'(psum_addr2), NPE'(tile_e % PD));
        chk("psum_write_addr", NPE'(psum_write_addr), NPE'(tile_e % PD));
        chk("busy", NPE'(busy), NPE'(phase != PhIdle));
        chk("done", NPE'(done), NPE'(phase == PhDone));
    endtask

    task automatic model_step(input logic st, input logic beat);
        case (phase)
            PhIdle: begin
                if (st) begin
                    mask_m = cfg_pe_mask;
                    n_m    = int'(cfg_num_tiles);
                    acc    = 0;
                    cur    = -1;
                    rd     = 0;
                    phase  = (n_m == 0) ? PhDone : PhPre;
                end
            end
            PhPre: begin
                if (beat) acc++;
                if (acc == D) begin
                    phase = PhRun;
                    cur   = 0;
                    rd    = 0;
                end
            end
            PhRun: begin
                if (beat) acc++;
                if (rd < D) rd++;
                if (rd == D && (cur == n_m - 1 || acc >= (cur + 2) * D)) begin
                    if (cur == n_m - 1) begin
                        phase = PhDrain;
                        dl    = ML;
                    end else begin
                        cur++;
                        rd = 0;
                    end
                end
            end
            PhDrain: begin
                dl--;
                if (dl == 0) phase = PhDone;
            end
            default: phase = PhIdle;
        endcase
    endtask

    // One clock cycle: drive, check against the model, advance the model.
    task automatic tick(input logic st, input logic vld);
        logic beat;
        start     = st;
        gbf_valid = vld;
        #1;
        check_outputs();
        beat = vld & ready_exp();
        if (MAC_en != '0) begin
            if (first_mac < 0) first_mac = tk;
            mac_seen++;
        end
        if (gbf_ready) ready_seen++;
        if (done) done_at = tk;
        tk++;
        @(posedge clk);
        model_step(st, beat);
        #1;
    endtask

    function automatic logic rand_vld(input int unsigned pct);
        return $urandom_range(99) < pct;
    endfunction

    task automatic clear_stats();
        tk         = 0;
        first_mac  = -1;
        done_at    = -1;
        mac_seen   = 0;
        ready_seen = 0;
    endtask

    // Runs one job to completion. Valid is forced low in ticks [glo,ghi];
    // hold_start keeps start high (with altered cfg) for the whole job.
    task automatic run_job(input int n, input logic [NPE-1:0] m, input int unsigned pct,
                           input int glo, input int ghi, input logic hold_start);
        logic vld;
        clear_stats();
        cfg_num_tiles = TW'(n);
        cfg_pe_mask   = m;
        tick(1'b1, rand_vld(pct));
        for (int i = 0; i < 400 && phase != PhIdle; i++) begin
            if (hold_start) begin
                cfg_num_tiles = TW'(5);
                cfg_pe_mask   = ~m;
            end
            vld = (tk >= glo && tk <= ghi) ? 1'b0 : rand_vld(pct);
            tick(hold_start, vld);
        end
        start = 1'b0;
        chk("job_finished_busy", NPE'(busy), '0);
    endtask

    task automatic rand_mask(output logic [NPE-1:0] m);
        for (int k = 0; k < NPE / 32; k++) m[k*32 +: 32] = $urandom();
        m[0] = 1'b1;
    endtask

    initial begin
        logic [NPE-1:0] m;
        reset         = 1'b1;
        start         = 1'b0;
        gbf_valid     = 1'b0;
        cfg_num_tiles = '0;
        cfg_pe_mask   = '0;
        model_reset();
        clear_stats();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state, including a valid bus word that must not be taken.
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);

        // Single tile, continuous bus.
        run_job(1, '1, 100, -1, -1, 1'b0);
        chk("t1_first_mac_tick", NPE'(first_mac), NPE'(1 + D));
        chk("t1_done_tick", NPE'(done_at), NPE'(1 + 2 * D + ML));
        chk("t1_mac_cycles", NPE'(mac_seen), NPE'(D));

        // Three tiles, 3-cycle bus gap at the start of the tile-1 load.
        run_job(3, '1, 100, 1 + D, 3 + D, 1'b0);
        chk("t3_mac_cycles", NPE'(mac_seen), NPE'(3 * D));
        chk("t3_done_tick", NPE'(done_at), NPE'(1 + D + 3 * D + 3 + ML));

        // Six tiles: psum address wraps, psum_en flips at tile 4.
        run_job(6, '1, 100, -1, -1, 1'b0);
        chk("t6_done_tick", NPE'(done_at), NPE'(1 + 7 * D + ML));
        chk("t6_psum_en_final", NPE'(psum_en), NPE'(1));
        chk("t6_psum_addr_final", NPE'(psum_write_addr), NPE'(1));

        // Zero tiles: immediate done, no bus or MAC activity.
        run_job(0, '1, 100, -1, -1, 1'b0);
        chk("t0_done_tick", NPE'(done_at), NPE'(1));
        chk("t0_mac_cycles", NPE'(mac_seen), '0);
        chk("t0_ready_cycles", NPE'(ready_seen), '0);

        // Start held high with different cfg while busy and during done.
        m = {{(NPE / 2){1'b0}}, {(NPE / 2){1'b1}}};
        run_job(2, m, 100, -1, -1, 1'b1);
        chk("busy_start_mac_cycles", NPE'(mac_seen), NPE'(2 * D));

        // Partial PE mask with a bursty bus.
        m = {{(NPE - 8){1'b0}}, 8'hFF};
        run_job(3, m, 60, -1, -1, 1'b0);
        chk("mask_mac_cycles", NPE'(mac_seen), NPE'(3 * D));

        // Reset in the middle of tile 2 of 4.
        clear_stats();
        cfg_num_tiles = TW'(4);
        cfg_pe_mask   = '1;
        tick(1'b1, 1'b1);
        for (int i = 0; i < 100 && !(phase == PhRun && cur == 2); i++) tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        chk("pre_reset_mac", MAC_en, '1);
        reset     = 1'b1;
        start     = 1'b0;
        gbf_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        chk("rst_mac_en", MAC_en, '0);
        chk("rst_busy", NPE'(busy), '0);
        chk("rst_sel", NPE'(actv_sel), '0);
        clear_stats();
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        chk("rst_no_done", NPE'(done_at), NPE'(-1));
        run_job(2, '1, 100, -1, -1, 1'b0);
        chk("post_rst_done_tick", NPE'(done_at), NPE'(1 + 3 * D + ML));

        // Randomized jobs.
        for (int j = 0; j < 8; j++) begin
            rand_mask(m);
            run_job(int'($urandom_range(1, 7)), m, $urandom_range(35, 100), -1, -1,
                    1'(($urandom_range(0, 1))));
            chk("rand_mac_cycles", NPE'(mac_seen), NPE'(n_m * D));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
